// File: rtl/control_unit.sv
// control_unit: fetch/decode/execute sequencer driving every strobe and select of the single-bus datapath.
// Outputs are decoded from the registered state and ir (plus con in br T7).
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con,
    output logic        run,
    output logic        HIout,
    output logic        LOout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        PCout,
    output logic        MDRout,
    output logic        InPortout,
    output logic        Cout,
    output logic        HIin,
    output logic        LOin,
    output logic        Zhighin,
    output logic        Zlowin,
    output logic        PCin,
    output logic        MDRin,
    output logic        InPortin,
    output logic        Cin,
    output logic        IRin,
    output logic        MARin,
    output logic        Yin,
    output logic        CONin,
    output logic        OutPortin,
    output logic        read,
    output logic        wren,
    output logic        AND,
    output logic        OR,
    output logic        ADD,
    output logic        SUB,
    output logic        MUL,
    output logic        DIV,
    output logic        SHR,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    output logic        IncPC,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout
);
    typedef enum logic [3:0] {T0, T1, T2, T3, T4, T5, T6, T7, T8, T9, RESET, HALT} state_t;

    state_t state, last;
    logic [9:0] t;
    logic [4:0] op;
    logic op_ld, op_ldi, op_st, op_ea, alu_r, alu_i, op_md, op_un, op_br, op_jr;
    logic op_in, op_out, op_mfhi, op_mflo, op_halt, alu_go;
    logic unused_ir;

    assign op        = ir[31:27];
    assign unused_ir = ^ir[26:0];
    assign op_ld     = op == 5'd0;
    assign op_ldi    = op == 5'd1;
    assign op_st     = op == 5'd2;
    assign op_ea     = op_ld | op_ldi | op_st;
    assign alu_r     = op >= 5'd3 && op <= 5'd10;
    assign alu_i     = op >= 5'd11 && op <= 5'd13;
    assign op_md     = op == 5'd14 || op == 5'd15;
    assign op_un     = op == 5'd16 || op == 5'd17;
    assign op_br     = op == 5'd18;
    assign op_jr     = op == 5'd19;
    assign op_in     = op == 5'd22;
    assign op_out    = op == 5'd23;
    assign op_mfhi   = op == 5'd24;
    assign op_mflo   = op == 5'd25;
    assign op_halt   = op == 5'd27;

    // Final step of each execute sequence; nop and undefined opcodes end at T3.
    assign last = op_ld ? T9 :
                  op_st ? T8 :
                  (op_md | op_br) ? T7 :
                  (op_ldi | alu_r | alu_i) ? T6 :
                  (op_un | op_in) ? T5 :
                  (op_jr | op_out | op_mfhi | op_mflo) ? T4 : T3;

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            state <= RESET;
        else if (state == RESET)
            state <= T0;
        else if (state == HALT || (state == T3 && op_halt))
            state <= HALT;
        else if (state == last)
            state <= T0;
        else
            state <= state_t'(state + 4'd1);
    end

    // One-hot step decode; RESET and HALT shift the bit out, leaving all zeros.
    assign t = 10'd1 << state;

    assign run       = |t;
    assign Cin       = |t;
    assign IncPC     = t[0];
    assign IRin      = t[3];
    assign PCout     = t[0] | (t[5] & op_br);
    assign MARin     = t[0] | (t[6] & (op_ld | op_st));
    assign Zlowin    = t[0] | (t[5] & (op_ea | alu_r | alu_i | op_md)) | (t[4] & op_un) | (t[6] & op_br);
    assign Zlowout   = t[1] | (t[6] & (op_ea | alu_r | alu_i | op_md)) | (t[5] & op_un) | (t[7] & op_br);
    assign PCin      = t[1] | (t[4] & op_jr) | (t[7] & op_br & con);
    assign read      = t[1] | t[2] | ((t[7] | t[8]) & op_ld);
    assign MDRin     = t[2] | (t[8] & op_ld) | (t[7] & op_st);
    assign MDRout    = t[3] | (t[9] & op_ld);
    assign wren      = t[8] & op_st;
    assign BAout     = t[4] & op_ea;
    assign Grb       = (t[4] & (op_ea | alu_r | alu_i | op_un)) | (t[5] & op_md);
    assign Grc       = t[5] & alu_r;
    assign Gra       = (t[4] & (op_md | op_br | op_jr | op_out | op_mfhi | op_mflo)) | (t[5] & (op_un | op_in))
                     | (t[6] & (op_ldi | alu_r | alu_i)) | (t[7] & op_st) | (t[9] & op_ld);
    assign Rin       = (t[4] & (op_mfhi | op_mflo)) | (t[5] & (op_un | op_in))
                     | (t[6] & (op_ldi | alu_r | alu_i)) | (t[9] & op_ld);
    assign Rout      = (t[4] & (alu_r | alu_i | op_md | op_un | op_br | op_jr | op_out))
                     | (t[5] & (alu_r | op_md)) | (t[7] & op_st);
    assign Yin       = (t[4] & (op_ea | alu_r | alu_i | op_md)) | (t[5] & op_br);
    assign Cout      = (t[5] & (op_ea | alu_i)) | (t[6] & op_br);
    assign Zhighin   = t[5] & op_md;
    assign Zhighout  = t[7] & op_md;
    assign HIin      = t[7] & op_md;
    assign LOin      = t[6] & op_md;
    assign CONin     = t[4] & op_br;
    assign InPortin  = t[4] & op_in;
    assign InPortout = t[5] & op_in;
    assign OutPortin = t[4] & op_out;
    assign HIout     = t[4] & op_mfhi;
    assign LOout     = t[4] & op_mflo;

    // The opcode-selected ALU step; address and branch-target adds are added to ADD separately.
    assign alu_go = (t[5] & (alu_r | alu_i | op_md)) | (t[4] & op_un);
    assign ADD = (alu_go & (op == 5'd3 || op == 5'd11)) | (t[5] & op_ea) | (t[6] & op_br);
    assign SUB = alu_go & (op == 5'd4);
    assign AND = alu_go & (op == 5'd5 || op == 5'd12);
    assign OR  = alu_go & (op == 5'd6 || op == 5'd13);
    assign SHR = alu_go & (op == 5'd7);
    assign SHL = alu_go & (op == 5'd8);
    assign ROR = alu_go & (op == 5'd9);
    assign ROL = alu_go & (op == 5'd10);
    assign MUL = alu_go & (op == 5'd14);
    assign DIV = alu_go & (op == 5'd15);
    assign NEG = alu_go & (op == 5'd16);
    assign NOT = alu_go & (op == 5'd17);
endmodule
